// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and defaults for the data-memory arbiter.
//   - owner_e : who currently owns arbitration (round-robin or locked host)
//   - gnt_e   : which side, if any, performs the memory access this cycle
//   - AW_DEF / DW_DEF : default address and data widths of the 8-bit core
package mem_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic {
    S_RR   = 1'b0,
    S_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

  // True while a locked host burst may take one more slot.
  function automatic logic burst_has_room(input logic [3:0] cnt,
                                          input logic [3:0] max);
    return (cnt < max);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the CPU-side, host-side and memory-side signals of the arbiter.
//   modport slave  : the arbiter's view (requests in, grants/bus out)
//   modport master : the surrounding system's view (CPU, host, memory)
//   CPU side  : cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_rdata, cpu_stall
//   Host side : host_req, host_we, host_lock, host_addr, host_wdata,
//               host_gnt, host_rdata, host_rvalid
//   Memory    : mem_addr, mem_din, mem_we, mem_dout
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_addr, mem_din, mem_we,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_addr, mem_din, mem_we,
    output mem_dout
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port data memory between the CPU datapath and the
//   host/debug port. Per-cycle round-robin arbitration, with an optional
//   host lock that keeps ownership for up to HOST_BURST_MAX consecutive
//   grants before the CPU is handed a forced slot. The CPU is stalled in
//   the same cycle it loses the memory and simply retries next cycle.
//
// Ports
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave (CPU, host and memory signals)
//
// Owner states
//   state  | meaning
//   S_RR   | per-cycle round-robin between CPU and host
//   S_HOST | host holds a locked burst; CPU only gets leftover/forced slots
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] BURST_MAX = 4'(HOST_BURST_MAX);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    burst_q, burst_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;

  gnt_e          gnt;
  logic          cpu_gnt;
  logic          host_gnt;
  logic          both_req;

  assign both_req = bus.cpu_req & bus.host_req;

  // Grant decision and owner next-state
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    gnt     = GNT_NONE;

    unique case (owner_q)
      S_RR: begin
        if (both_req) begin
          // last_q=1 means the host won the previous contest
          gnt    = last_q ? GNT_CPU : GNT_HOST;
          last_d = ~last_q;
        end else if (bus.cpu_req) begin
          gnt = GNT_CPU;
        end else if (bus.host_req) begin
          gnt = GNT_HOST;
        end

        if ((gnt == GNT_HOST) && bus.host_lock) begin
          owner_d = S_HOST;
          burst_d = 4'd1;
        end
      end

      S_HOST: begin
        if (bus.host_req && burst_has_room(burst_q, BURST_MAX)) begin
          gnt = GNT_HOST;
        end else if (bus.cpu_req) begin
          gnt = GNT_CPU;
        end

        if ((gnt == GNT_HOST) && bus.host_lock) begin
          burst_d = burst_q + 4'd1;
        end else begin
          // Host dropped its request, released the lock, or used up the
          // burst budget: fall back to round-robin with the CPU favoured.
          owner_d = S_RR;
          burst_d = 4'd0;
          last_d  = 1'b1;
        end
      end
    endcase

    // Nothing touches memory while reset is asserted.
    if (rst) begin
      gnt = GNT_NONE;
    end
  end

  assign cpu_gnt  = (gnt == GNT_CPU);
  assign host_gnt = (gnt == GNT_HOST);

  // Memory mux and CPU/host side outputs
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    bus.mem_we    = 1'b0;
    if (cpu_gnt) begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
      bus.mem_we   = bus.cpu_we;
    end else if (host_gnt) begin
      bus.mem_addr = bus.host_addr;
      bus.mem_din  = bus.host_wdata;
      bus.mem_we   = bus.host_we;
    end
  end

  // Load data is only meaningful when the CPU is not stalled.
  assign bus.cpu_rdata   = bus.mem_dout;
  assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt & ~rst;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;

  // Host read capture: one-cycle rvalid pulse after a granted read.
  always_comb begin
    host_rvalid_d = host_gnt & ~bus.host_we;
    host_rdata_d  = host_rdata_q;
    if (host_rvalid_d) begin
      host_rdata_d = bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= S_RR;
      last_q        <= 1'b1;
      burst_q       <= 4'd0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_q        <= last_d;
      burst_q       <= burst_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath and a host/debug port (loader, inspector).
- Sits between the decoder/register file (CPU side) and the memory block.
- Arbitrates per cycle: round-robin fairness, plus an optional host lock for atomic bursts.
- Stalls the CPU (gating PC and register writes) whenever the CPU loses a memory cycle.

Parameters:
- AW, 8, address width (matches the 8-bit data path).
- DW, 8, data width.
- HOST_BURST_MAX, 4, maximum consecutive locked host grants before the CPU must get one slot; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU memory access this cycle (load or store instruction)
- cpu_we  in  1  CPU store
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data (ALU result)
- cpu_rdata  out  DW  load data, combinational from mem_dout
- cpu_stall  out  1  CPU must hold PC, reg_we and zf this cycle
- host_req  in  1  host access request
- host_we  in  1  host write
- host_lock  in  1  host requests to keep ownership next cycle
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  DW  registered host read data
- host_rvalid  out  1  host_rdata valid (1 cycle after a granted read)
- mem_addr  out  AW  to memory addr
- mem_din  out  DW  to memory din
- mem_we  out  1  to memory we
- mem_dout  in  DW  from memory dout (combinational read)

Behaviour:
- Registered state:
  - owner: S_RR (round-robin) or S_HOST (locked).
  - last (1 = host won the last contested cycle).
  - burst_cnt (4 bits).
  - host_rdata, host_rvalid.
- Reset (synchronous, rst=1 at posedge):
  - owner=S_RR, last=1 (CPU wins the first contest), burst_cnt=0, host_rdata=0, host_rvalid=0.
  - While rst is high, combinational outputs are forced: host_gnt=0, cpu_stall=0, mem_we=0, mem_addr=0, mem_din=0.
- Grant decision (combinational), in S_RR:
  - Only cpu_req: CPU granted.
  - Only host_req: host granted.
  - Both: grant to !last, then last toggles.
  - Neither: no grant, mem_we=0, last unchanged.
- Grant decision in S_HOST:
  - Host granted if host_req=1 and burst_cnt<HOST_BURST_MAX.
  - Otherwise CPU granted if cpu_req=1 (forced slot), else nothing.
- Transitions:
  - S_RR→S_HOST: host granted and host_lock=1; burst_cnt←1.
  - S_HOST stays: host granted and host_lock=1; burst_cnt++.
  - S_HOST→S_RR, on any of:
    - host_req=0;
    - host_lock=0 on a granted cycle;
    - burst_cnt reached HOST_BURST_MAX, after the forced CPU slot or an idle cycle.
  - On exit: burst_cnt←0, last←1.
- Mux:
  - Granted side drives mem_addr and mem_din.
  - mem_we = granted_we.
  - cpu_rdata = mem_dout always (valid only when not stalled).
- Stall: cpu_stall = cpu_req & !cpu_granted. Same cycle, no added latency. CPU retries the identical access next cycle.
- Host read: on a granted read, host_rdata←mem_dout and host_rvalid←1 at the next edge. Otherwise host_rvalid←0 (single-cycle pulse).
- Host write: committed at the same edge as the grant; host_rvalid stays 0.
- Reset mid-burst: owner returns to S_RR, any pending host_rvalid is dropped, and no write occurs in the reset cycle.
- The CPU can never be starved for more than HOST_BURST_MAX consecutive cycles. The host is never starved more than 1 cycle in S_RR.

Decomposition:
- Shared package: owner-state encoding (S_RR=0, S_HOST=1) and default widths AW/DW.
- No sub-module needed; grant logic and state register stay in one module.
- Instantiate in the top level between the decoder/ALU outputs and the memory block. cpu_stall is ANDed into pc_we, reg_we and the zf enable.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr=3, wdata=0x5A; host idle → mem_we=1, mem_addr=3, cpu_stall=0; next-cycle read of addr 3 returns 0x5A.
- Contention after reset: both request reads in 2 cycles → cycle0 CPU granted (host_gnt=0); cycle1 host granted, cpu_stall=1; host_rvalid=1 in cycle2.
- Host write: host_we=1, addr=7, wdata=0xC3 granted → mem7=0xC3 after the edge; host_rvalid stays 0.
- Locked burst, HOST_BURST_MAX=4, cpu_req held → host granted for 4 cycles (cpu_stall=1 each), 5th cycle CPU granted, then round-robin resumes.
- Lock released early: host_lock=0 on the 2nd granted host cycle → owner back to S_RR; next contested cycle goes to the CPU.
- Reset mid-burst: assert rst in the 2nd locked cycle with a host write pending → mem_we=0, host_rvalid=0; after release, first contest goes to the CPU.
